// File: rtl/n_bit_counter.sv
// n_bit_counter
//   Free-running unsigned up-counter, N bits wide, wrapping modulo 2^N.
//   Intended as a shared timebase: several widths are instantiated side by
//   side from this one source.
//
// Ports
//   clk   in   1  clock, count advances on the rising edge
//   rstn  in   1  asynchronous active-low reset, clears the count at once
//   out   out  N  current count, taken straight from the count register
//
// Release of rstn is expected to be synchronous to clk (e.g. on a falling
// edge); there is no reset synchroniser inside this block.

module n_bit_counter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rstn,
  output logic [N-1:0] out
);

  generate
    if (N < 1 || N > 64) begin : g_bad_width
      $error("n_bit_counter: N must be in 1..64");
    end
  endgenerate

  logic [N-1:0] cnt_q;
  logic [N-1:0] cnt_d;

  // Carry out of the MSB drops off, which gives the modulo-2^N wrap.
  always_comb begin
    cnt_d = cnt_q + N'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out = cnt_q;

endmodule

// File: tb/tb_n_bit_counter.sv
module tb_n_bit_counter;

  logic        clk;
  logic        rstn;
  logic [0:0]  o1;
  logic [3:0]  o4;
  logic [7:0]  o8;
  logic [15:0] o16;
  logic [31:0] o32;
  logic [63:0] o64;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: number of rising edges seen since the last release.
  longint unsigned k = 0;

  n_bit_counter #(.N(1))  u_c1  (.clk(clk), .rstn(rstn), .out(o1));
  n_bit_counter #(.N(4))  u_c4  (.clk(clk), .rstn(rstn), .out(o4));
  n_bit_counter #(.N(8))  u_c8  (.clk(clk), .rstn(rstn), .out(o8));
  n_bit_counter #(.N(16)) u_c16 (.clk(clk), .rstn(rstn), .out(o16));
  n_bit_counter #(.N(32)) u_c32 (.clk(clk), .rstn(rstn), .out(o32));
  n_bit_counter #(.N(64)) u_c64 (.clk(clk), .rstn(rstn), .out(o64));

  initial begin
    clk = 1'b0;
    forever #2 clk = ~clk;
  end

  typedef struct {
    string       name;
    int unsigned edges;
    logic [3:0]  e4;
    logic [7:0]  e8;
    logic [15:0] e16;
    logic [31:0] e32;
  } vec_t;

  vec_t table_v[$];

  function automatic longint unsigned model_out(int n);
    if (n >= 64) return k;
    return k % (64'd1 << n);
  endfunction

  task automatic chk_one(string tag, string sig, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s %s: got %0d, expected %0d", tag, sig, act, exp);
    end
  endtask

  task automatic chk_model(string tag);
    chk_one(tag, "out1",  64'(o1),  model_out(1));
    chk_one(tag, "out4",  64'(o4),  model_out(4));
    chk_one(tag, "out8",  64'(o8),  model_out(8));
    chk_one(tag, "out16", 64'(o16), model_out(16));
    chk_one(tag, "out32", 64'(o32), model_out(32));
    chk_one(tag, "out64", o64,      model_out(64));
  endtask

  task automatic chk_zero(string tag);
    chk_one(tag, "out1",  64'(o1),  64'd0);
    chk_one(tag, "out4",  64'(o4),  64'd0);
    chk_one(tag, "out8",  64'(o8),  64'd0);
    chk_one(tag, "out16", 64'(o16), 64'd0);
    chk_one(tag, "out32", 64'(o32), 64'd0);
    chk_one(tag, "out64", o64,      64'd0);
  endtask

  // Run n rising edges with rstn high, then sample 1 unit after the last.
  task automatic advance(int unsigned n);
    repeat (n) @(posedge clk);
    k += n;
    #1;
  endtask

  // Drop rstn between edges, confirm the clear is immediate, hold for
  // 'hold' further edges, then release on a falling edge.
  task automatic mid_pulse(string tag, int hold);
    rstn = 1'b0;
    k = 0;
    #1;
    chk_zero({tag, "_async"});
    repeat (hold) @(posedge clk);
    @(negedge clk);
    chk_zero({tag, "_held"});
    rstn = 1'b1;
  endtask

  initial begin
    // Cumulative walk from release: expected values computed by hand.
    table_v.push_back('{"first_edge",  1,     4'd1,  8'd1,   16'd1,     32'd1});
    table_v.push_back('{"second_edge", 1,     4'd2,  8'd2,   16'd2,     32'd2});
    table_v.push_back('{"k14",         12,    4'd14, 8'd14,  16'd14,    32'd14});
    table_v.push_back('{"k15",         1,     4'd15, 8'd15,  16'd15,    32'd15});
    table_v.push_back('{"wrap4",       1,     4'd0,  8'd16,  16'd16,    32'd16});
    table_v.push_back('{"k255",        239,   4'd15, 8'd255, 16'd255,   32'd255});
    table_v.push_back('{"wrap8",       1,     4'd0,  8'd0,   16'd256,   32'd256});
    table_v.push_back('{"k65535",      65279, 4'd15, 8'd255, 16'd65535, 32'd65535});
    table_v.push_back('{"wrap16",      1,     4'd0,  8'd0,   16'd0,     32'd65536});

    rstn = 1'b0;
    #1;
    chk_zero("pre_clk_reset");
    repeat (5) begin
      @(posedge clk);
      #1;
      chk_zero("reset_hold");
    end

    @(negedge clk);
    rstn = 1'b1;
    k = 0;
    #1;
    chk_zero("release_before_edge");

    foreach (table_v[i]) begin
      advance(table_v[i].edges);
      chk_one(table_v[i].name, "out4",  64'(o4),  64'(table_v[i].e4));
      chk_one(table_v[i].name, "out8",  64'(o8),  64'(table_v[i].e8));
      chk_one(table_v[i].name, "out16", 64'(o16), 64'(table_v[i].e16));
      chk_one(table_v[i].name, "out32", 64'(o32), 64'(table_v[i].e32));
      chk_one(table_v[i].name, "out64", o64,      64'(table_v[i].e32));
      chk_one(table_v[i].name, "out1",  64'(o1),  64'(table_v[i].e32 & 32'd1));
    end

    // Mid-cycle reset pulse, then count 1, 2, 3 again.
    advance(7);
    mid_pulse("mid_pulse", 1);
    for (int i = 1; i <= 3; i++) begin
      advance(1);
      chk_one("recount", "out4",  64'(o4),  64'(i));
      chk_one("recount", "out32", 64'(o32), 64'(i));
      chk_one("recount", "out64", o64,      64'(i));
    end

    // rstn falls in the same time step as a rising edge: reset wins.
    advance(5);
    @(posedge clk);
    rstn = 1'b0;
    k = 0;
    #1;
    chk_zero("reset_at_edge");
    @(negedge clk);
    rstn = 1'b1;

    // Randomised runs and reset pulses against the edge-count model.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        mid_pulse("rand_pulse", int'($urandom_range(0, 3)));
        advance($urandom_range(1, 4));
      end else begin
        advance($urandom_range(1, 40));
      end
      chk_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
